alu_op_arbiter: RTL and testbench
=================================

ALU_OP_ARBITER -- requirements
Module: alu_op_arbiter

Interface
REQ-001 Parameter: RR_INIT, default 0, requester given priority first after reset (0 or 1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1 each  requester N has an operation pending.
REQ-005 req0_ready / req1_ready  output  1 each  operation of requester N accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  8 each  operands.
REQ-007 req0_sel / req1_sel  input  3 each  logic op code: 011 AND, 100 OR, 101 XOR, 110 NOT a.
REQ-008 lu_enable  output  1  enable to the shared logic unit.
REQ-009 lu_a, lu_b  output  8 each; lu_sel  output  3  operands and op code to the logic unit.
REQ-010 lu_result  input  16  combinational result from the logic unit.
REQ-011 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-012 rsp_id  output  1  requester that owns the response; rsp_data  output  16  result.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, EXEC, RESP; IDLE->EXEC on acceptance, EXEC->RESP unconditionally, RESP->IDLE on rsp_valid & rsp_ready, otherwise hold.
REQ-015 Grant (IDLE only): one valid -> that requester; both valid -> requester indicated by round-robin pointer rr; none -> no grant.
REQ-016 reqN_ready SHALL be 1 only in IDLE for the granted requester; never both high; 0 in EXEC and RESP.
REQ-017 On acceptance (cycle T) a, b, sel and requester id SHALL be registered; rr SHALL point to the non-granted requester from T+1.
REQ-018 In EXEC (T+1), lu_enable SHALL be 1 and lu_a/lu_b/lu_sel driven from the registered values; lu_result captured into rsp_data at end of T+1.
REQ-019 lu_enable SHALL be 0 in IDLE and RESP; lu_a/lu_b/lu_sel hold their last registered values.
REQ-020 rsp_valid SHALL rise at T+2 and hold, with rsp_id/rsp_data stable, until rsp_ready sampled high.
REQ-021 Back-pressure: while in RESP with rsp_ready low, no new request accepted; requester inputs ignored.
REQ-022 Next acceptance no earlier than cycle after RESP handshake; peak throughput one op per 3 cycles.
REQ-023 Requester inputs changing while not ready SHALL NOT affect the operation in flight.
REQ-024 rsp_data upper 8 bits SHALL be passed through from lu_result unmodified (no masking).

Reset
REQ-025 rst_n low SHALL immediately, independent of clk, force state IDLE, rsp_valid 0, lu_enable 0, req0_ready/req1_ready 0, busy 0, rsp_data 0, rsp_id 0, operand/sel registers 0, rr = RR_INIT.
REQ-026 Reset during EXEC or RESP SHALL discard the in-flight operation; no response emitted after release.
REQ-027 First acceptance possible in the first rising edge with rst_n high.

Configuration
REQ-028 Macro ALU_ARB_ERR_EN defined: output rsp_err (1 bit) exists; sel outside 011..110 SHALL skip EXEC (lu_enable stays 0), go IDLE->RESP with rsp_data=0, rsp_err=1, response at T+1; legal ops give rsp_err=0; rsp_err reset 0.
REQ-029 Macro ALU_ARB_ERR_EN undefined: rsp_err port absent; every sel forwarded through EXEC unchanged, response at T+2.

Verification
REQ-030 Single op: req0 a=0xF0 b=0x3C sel=011 at T -> lu_enable=1 at T+1, rsp_valid at T+2, rsp_id=0, rsp_data=0x0030.
REQ-031 Contention: both valid from reset, RR_INIT=0, req0 OR 0x0F|0xF0, req1 XOR 0xFF^0x0F -> first rsp_id=0 data=0x00FF, second rsp_id=1 data=0x00F0; grants alternate over 4 ops.
REQ-032 Back-pressure: rsp_ready low 5 cycles after rsp_valid -> rsp_valid/rsp_data stable, req*_ready 0, busy 1 throughout; handshake then IDLE next cycle.
REQ-033 NOT: req1 a=0xA5 sel=110 -> rsp_data=0x005A, rsp_id=1.
REQ-034 Reset mid-op: rst_n low during EXEC -> outputs reset asynchronously, no rsp_valid after release, rr=RR_INIT.
REQ-035 Illegal sel=111: with ALU_ARB_ERR_EN -> rsp_err=1, rsp_data=0, lu_enable never high, rsp at T+1; without -> rsp_data=0x0000 at T+2.

Source files
------------

// File: rtl/alu_op_arbiter.sv
// Purpose: round-robin arbiter that gives two requesters turns on one shared logic unit.
// Latency: the response appears two cycles after acceptance, or one cycle for an illegal op when ALU_ARB_ERR_EN is defined.
// Backpressure: only one op is in flight at a time. While the response waits for rsp_ready, neither requester sees ready.
//
// Ports:
//   clk, rst_n               clock; asynchronous active-low reset
//   reqN_valid/_ready        per-requester handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_sel operands and op code (011 AND, 100 OR, 101 XOR, 110 NOT a)
//   lu_enable, lu_a/b/sel    drive the shared logic unit during the execute cycle
//   lu_result                combinational result returned by the logic unit
//   rsp_valid/_ready         response handshake
//   rsp_id, rsp_data         owning requester and the 16-bit result
//   rsp_err                  only present when ALU_ARB_ERR_EN is defined: flags an illegal op code
//   busy                     high whenever an op is in flight
// Optional feature macro: ALU_ARB_ERR_EN.
module alu_op_arbiter #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic [2:0]  req0_sel,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    input  logic [2:0]  req1_sel,
    output logic        lu_enable,
    output logic [7:0]  lu_a,
    output logic [7:0]  lu_b,
    output logic [2:0]  lu_sel,
    input  logic [15:0] lu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
`ifdef ALU_ARB_ERR_EN
    output logic        rsp_err,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        rr_q, rr_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [2:0]  sel_q, sel_d;
    logic        id_q, id_d;
    logic [15:0] rsp_data_q, rsp_data_d;
`ifdef ALU_ARB_ERR_EN
    logic        rsp_err_q, rsp_err_d;
`endif

    logic        grant_id;
    logic        accept;
    logic [7:0]  g_a;
    logic [7:0]  g_b;
    logic [2:0]  g_sel;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        a_d        = a_q;
        b_d        = b_q;
        sel_d      = sel_q;
        id_d       = id_q;
        rsp_data_d = rsp_data_q;
`ifdef ALU_ARB_ERR_EN
        rsp_err_d  = rsp_err_q;
`endif
        lu_enable  = 1'b0;
        accept     = 1'b0;

        // A lone requester wins outright. When both are valid, the rr pointer decides.
        grant_id = (req0_valid && req1_valid) ? rr_q : req1_valid;
        g_a      = grant_id ? req1_a   : req0_a;
        g_b      = grant_id ? req1_b   : req0_b;
        g_sel    = grant_id ? req1_sel : req0_sel;

        case (state_q)
            ST_IDLE: begin
                // The state register already reads IDLE during reset. Gating with rst_n
                // keeps ready low until reset is released.
                accept = (req0_valid || req1_valid) && rst_n;
                if (accept) begin
                    id_d    = grant_id;
                    a_d     = g_a;
                    b_d     = g_b;
                    sel_d   = g_sel;
                    rr_d    = ~grant_id;
                    state_d = ST_EXEC;
`ifdef ALU_ARB_ERR_EN
                    rsp_err_d = 1'b0;
                    if ((g_sel < 3'b011) || (g_sel == 3'b111)) begin
                        // An illegal op never reaches the logic unit. It answers next cycle with an error.
                        state_d    = ST_RESP;
                        rsp_data_d = 16'h0000;
                        rsp_err_d  = 1'b1;
                    end
`endif
                end
            end
            ST_EXEC: begin
                lu_enable  = 1'b1;
                rsp_data_d = lu_result;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_q       <= RR_INIT;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            sel_q      <= 3'b000;
            id_q       <= 1'b0;
            rsp_data_q <= 16'h0000;
`ifdef ALU_ARB_ERR_EN
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sel_q      <= sel_d;
            id_q       <= id_d;
            rsp_data_q <= rsp_data_d;
`ifdef ALU_ARB_ERR_EN
            rsp_err_q  <= rsp_err_d;
`endif
        end
    end

    assign req0_ready = accept & ~grant_id;
    assign req1_ready = accept & grant_id;
    assign lu_a       = a_q;
    assign lu_b       = b_q;
    assign lu_sel     = sel_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = id_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = (state_q != ST_IDLE);
`ifdef ALU_ARB_ERR_EN
    assign rsp_err    = rsp_err_q;
`endif

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Purpose: self-checking bench for alu_op_arbiter, with a transaction-level reference model.
// Latency: not applicable (bench).
// Backpressure: rsp_ready is driven by directed sequences and by random stimulus.
module tb_alu_op_arbiter;

`ifdef ALU_ARB_ERR_EN
    localparam bit ERR_EN = 1'b1;
    logic rsp_err;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_sel, req1_sel;
    logic        lu_enable;
    logic [7:0]  lu_a, lu_b;
    logic [2:0]  lu_sel;
    logic [15:0] lu_result;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [15:0] rsp_data;
    logic        busy;
    logic [7:0]  lu_hi;

    int n_vec = 0;
    int n_err = 0;

    alu_op_arbiter #(.RR_INIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .lu_enable(lu_enable), .lu_a(lu_a), .lu_b(lu_b), .lu_sel(lu_sel),
        .lu_result(lu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data),
`ifdef ALU_ARB_ERR_EN
        .rsp_err(rsp_err),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural logic unit. The upper byte comes from lu_hi, so pass-through of those bits is visible.
    function automatic logic [7:0] lu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        case (s)
            3'b011:  return a & b;
            3'b100:  return a | b;
            3'b101:  return a ^ b;
            3'b110:  return ~a;
            default: return 8'h00;
        endcase
    endfunction

    always_comb lu_result = {lu_hi, lu_fn(lu_a, lu_b, lu_sel)};

    function automatic bit err_skip(input logic [2:0] s);
        return ERR_EN && ((s < 3'b011) || (s == 3'b111));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  sel;
        logic [7:0]  hi;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t tbl[9];

    // Reference-model state for the random phase.
    bit          m_busy, m_prio, m_id, m_skip, e0, e1;
    int          m_acc, m_rsp;
    logic [7:0]  m_a, m_b;
    logic [2:0]  m_sel;
    logic [15:0] m_data;
    bit          skip;
    int          r;

    initial begin
        tbl[0] = '{1'b0, 8'hF0, 8'h3C, 3'b011, 8'h00, 16'h0030, 1'b0};
        tbl[1] = '{1'b1, 8'hA5, 8'h00, 3'b110, 8'h00, 16'h005A, 1'b0};
        tbl[2] = '{1'b0, 8'h0F, 8'hF0, 3'b100, 8'h00, 16'h00FF, 1'b0};
        tbl[3] = '{1'b1, 8'hFF, 8'h0F, 3'b101, 8'h00, 16'h00F0, 1'b0};
        tbl[4] = '{1'b1, 8'h5A, 8'h3C, 3'b011, 8'h00, 16'h0018, 1'b0};
        tbl[5] = '{1'b0, 8'h12, 8'h34, 3'b101, 8'h00, 16'h0026, 1'b0};
        tbl[6] = '{1'b0, 8'hC3, 8'h77, 3'b111, 8'h00, 16'h0000, 1'b1};
        tbl[7] = '{1'b1, 8'h00, 8'hFF, 3'b000, 8'h00, 16'h0000, 1'b1};
        tbl[8] = '{1'b0, 8'h81, 8'h18, 3'b100, 8'hAB, 16'hAB99, 1'b0};

        // Hold reset with both requesters valid. Nothing may be granted and every output must read zero.
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        lu_hi = 8'h00;
        req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'hFF; req0_sel = 3'b100;
        req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'hFF; req1_sel = 3'b101;
        repeat (2) @(posedge clk);
        #3;
        chk("reset_req0_ready", req0_ready, 0);
        chk("reset_req1_ready", req1_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_lu_enable", lu_enable, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_lu_a", lu_a, 0);
        chk("reset_lu_sel", lu_sel, 0);
`ifdef ALU_ARB_ERR_EN
        chk("reset_rsp_err", rsp_err, 0);
`endif
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        tick();

        // Table: one op at a time from a single requester.
        for (int i = 0; i < 9; i++) begin
            lu_hi = tbl[i].hi;
            if (tbl[i].id) begin
                req1_valid = 1'b1; req1_a = tbl[i].a; req1_b = tbl[i].b; req1_sel = tbl[i].sel;
            end else begin
                req0_valid = 1'b1; req0_a = tbl[i].a; req0_b = tbl[i].b; req0_sel = tbl[i].sel;
            end
            #1;
            chk("tbl_ready", {req1_ready, req0_ready}, tbl[i].id ? 2'b10 : 2'b01);
            tick();
            req0_valid = 1'b0; req1_valid = 1'b0;
            req0_a = 8'($urandom); req1_a = 8'($urandom);
            req0_sel = 3'($urandom); req1_sel = 3'($urandom);
            #1;
            skip = err_skip(tbl[i].sel);
            chk("tbl_lu_enable", lu_enable, !skip);
            chk("tbl_rsp_valid_early", rsp_valid, skip);
            if (!skip) begin
                chk("tbl_lu_a", lu_a, tbl[i].a);
                chk("tbl_lu_b", lu_b, tbl[i].b);
                chk("tbl_lu_sel", lu_sel, tbl[i].sel);
                tick();
                #1;
                chk("tbl_rsp_valid", rsp_valid, 1);
            end
            chk("tbl_rsp_id", rsp_id, tbl[i].id);
            chk("tbl_rsp_data", rsp_data, tbl[i].exp_data);
`ifdef ALU_ARB_ERR_EN
            chk("tbl_rsp_err", rsp_err, tbl[i].exp_err);
`endif
            tick();
            #1;
            chk("tbl_idle_busy", busy, 0);
        end
        lu_hi = 8'h00;

        // Contention: both requesters are valid from reset, and the grant must alternate from requester 0.
        req0_valid = 1'b1; req0_a = 8'h0F; req0_b = 8'hF0; req0_sel = 3'b100;
        req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h0F; req1_sel = 3'b101;
        rsp_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("cont_grant", {req1_ready, req0_ready}, (k % 2) ? 2'b10 : 2'b01);
            tick();
            tick();
            #1;
            chk("cont_rsp_valid", rsp_valid, 1);
            chk("cont_rsp_id", rsp_id, k % 2);
            chk("cont_rsp_data", rsp_data, (k % 2) ? 16'h00F0 : 16'h00FF);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Back-pressure: the response is held for five cycles while both requesters keep pushing.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'h3C; req0_sel = 3'b011;
        #1;
        chk("bp_accept", {req1_ready, req0_ready}, 2'b01);
        tick();
        req1_valid = 1'b1; req0_a = 8'h11; req1_a = 8'h22; req1_b = 8'h33; req1_sel = 3'b100;
        #1;
        chk("bp_lu_enable", lu_enable, 1);
        chk("bp_exec_ready", {req1_ready, req0_ready}, 2'b00);
        tick();
        for (int j = 0; j < 5; j++) begin
            req0_a = 8'($urandom); req0_sel = 3'($urandom); req1_b = 8'($urandom);
            #1;
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, 16'h0030);
            chk("bp_rsp_id", rsp_id, 0);
            chk("bp_ready", {req1_ready, req0_ready}, 2'b00);
            chk("bp_busy", busy, 1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_hs_valid", rsp_valid, 1);
        tick();
        #1;
        chk("bp_after_busy", busy, 0);
        chk("bp_after_valid", rsp_valid, 0);
        chk("bp_after_grant", {req1_ready, req0_ready}, 2'b10);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Reset arrives mid-op, during EXEC. It must act at once, without a clock edge.
        req0_valid = 1'b1; req0_a = 8'h77; req0_b = 8'h0F; req0_sel = 3'b100;
        #1;
        chk("rst_mid_accept", {req1_ready, req0_ready}, 2'b01);
        tick();
        req1_valid = 1'b1;
        #1;
        chk("rst_mid_lu_enable", lu_enable, 1);
        chk("rst_mid_lu_a", lu_a, 8'h77);
        rst_n = 1'b0;
        #1;
        chk("rst_async_lu_enable", lu_enable, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_rsp_valid", rsp_valid, 0);
        chk("rst_async_ready", {req1_ready, req0_ready}, 2'b00);
        chk("rst_async_rsp_data", rsp_data, 0);
        chk("rst_async_lu_a", lu_a, 0);
        chk("rst_async_lu_sel", lu_sel, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("rst_no_rsp", rsp_valid, 0);
            chk("rst_no_busy", busy, 0);
            tick();
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_rr_init", {req1_ready, req0_ready}, 2'b01);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Random traffic against the transaction-level model.
        do_reset();
        m_busy = 1'b0; m_prio = 1'b0; m_data = 16'h0000;
        for (int c = 0; c < 1500; c++) begin
            req0_valid = ($urandom_range(0, 99) < 60);
            req1_valid = ($urandom_range(0, 99) < 60);
            req0_a = 8'($urandom); req0_b = 8'($urandom);
            req1_a = 8'($urandom); req1_b = 8'($urandom);
            r = $urandom_range(0, 11);
            req0_sel = (r < 8) ? 3'(r) : 3'(r - 5);
            r = $urandom_range(0, 11);
            req1_sel = (r < 8) ? 3'(r) : 3'(r - 5);
            rsp_ready = ($urandom_range(0, 99) < 70);
            lu_hi = 8'($urandom);
            #1;
            if (!m_busy) begin
                e0 = req0_valid && (!req1_valid || !m_prio);
                e1 = req1_valid && (!req0_valid || m_prio);
                chk("rnd_ready0", req0_ready, e0);
                chk("rnd_ready1", req1_ready, e1);
                chk("rnd_idle_busy", busy, 0);
                chk("rnd_idle_rsp_valid", rsp_valid, 0);
                chk("rnd_idle_lu_enable", lu_enable, 0);
                if (e0 || e1) begin
                    m_busy = 1'b1;
                    m_id   = e1;
                    m_a    = e1 ? req1_a : req0_a;
                    m_b    = e1 ? req1_b : req0_b;
                    m_sel  = e1 ? req1_sel : req0_sel;
                    m_skip = err_skip(m_sel);
                    m_acc  = c;
                    m_rsp  = c + (m_skip ? 1 : 2);
                    m_prio = !e1;
                    m_data = 16'h0000;
                end
            end else begin
                chk("rnd_busy_ready", {req1_ready, req0_ready}, 2'b00);
                chk("rnd_busy", busy, 1);
                chk("rnd_lu_enable", lu_enable, (c == m_acc + 1) && !m_skip);
                if ((c == m_acc + 1) && !m_skip) begin
                    chk("rnd_lu_a", lu_a, m_a);
                    chk("rnd_lu_b", lu_b, m_b);
                    chk("rnd_lu_sel", lu_sel, m_sel);
                    m_data = {lu_hi, lu_fn(m_a, m_b, m_sel)};
                end
                chk("rnd_rsp_valid", rsp_valid, c >= m_rsp);
                if (c >= m_rsp) begin
                    chk("rnd_rsp_id", rsp_id, m_id);
                    chk("rnd_rsp_data", rsp_data, m_data);
`ifdef ALU_ARB_ERR_EN
                    chk("rnd_rsp_err", rsp_err, m_skip);
`endif
                    if (rsp_ready) m_busy = 1'b0;
                end
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
